// File: rtl/button_debouncer.sv
// button_debouncer
//   Multi-channel switch debouncer. Each raw input is brought into the clk
//   domain through a two-flop synchronizer, then filtered by a per-channel
//   counter that advances only on sample_pulse strobes. A debounced level
//   flips only after PULSE_CNT_MAX consecutive samples disagree with it. Any
//   single agreeing sample restarts the count.
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   sample_pulse  : one-cycle sample strobe (held high = one sample per cycle)
//   glitchy_in    : raw asynchronous levels, WIDTH channels
//   debounced_out : registered filtered level per channel
//   rise_pulse    : one-cycle strobe when a channel's debounced level goes 0->1
//   fall_pulse    : one-cycle strobe when a channel's debounced level goes 1->0
module button_debouncer #(
  parameter int WIDTH         = 4,
  parameter int PULSE_CNT_MAX = 25,
  parameter int CNT_WIDTH     = $clog2(PULSE_CNT_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_pulse,
  input  logic [WIDTH-1:0] glitchy_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Terminal count: the PULSE_CNT_MAX-th disagreeing sample arrives while the
  // counter already holds PULSE_CNT_MAX-1.
  localparam logic [CNT_WIDTH-1:0] LP_TC = CNT_WIDTH'(PULSE_CNT_MAX - 1);

  logic [WIDTH-1:0]     r_sync1;
  logic [WIDTH-1:0]     r_sync2;
  logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]     r_deb;
  logic [WIDTH-1:0]     r_rise;
  logic [WIDTH-1:0]     r_fall;

  logic [CNT_WIDTH-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0]     w_deb_nxt;
  logic [WIDTH-1:0]     w_rise_nxt;
  logic [WIDTH-1:0]     w_fall_nxt;

  always_comb begin
    w_deb_nxt  = r_deb;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (sample_pulse) begin
        if (r_sync2[i] == r_deb[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] >= LP_TC) begin
          // Terminal sample: flip the level and strobe the matching edge.
          // Using >= keeps the counter from ever running past LP_TC.
          w_deb_nxt[i]  = ~r_deb[i];
          w_cnt_nxt[i]  = '0;
          w_rise_nxt[i] = ~r_deb[i];
          w_fall_nxt[i] = r_deb[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= glitchy_in;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign debounced_out = r_deb;
  assign rise_pulse    = r_rise;
  assign fall_pulse    = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Bench for button_debouncer with WIDTH=2, PULSE_CNT_MAX=4. Each directed
//   step pushes the edge event it expects (strobe values, level, and the
//   sample index at which it must occur) into a queue; a monitor pops one
//   entry for every cycle on which the DUT shows a rise/fall strobe.
module tb_button_debouncer;

  localparam int W  = 2;
  localparam int PM = 4;

  logic         clk;
  logic         rst_n;
  logic         sample_pulse;
  logic [W-1:0] glitchy_in;
  logic [W-1:0] debounced_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  typedef struct packed {
    logic [1:0]  rise;
    logic [1:0]  fall;
    logic [1:0]  deb;
    logic [31:0] samp;
  } exp_t;

  exp_t exp_q[$];
  int   n_err  = 0;
  int   n_chk  = 0;
  int   n_samp = 0;
  bit   cont   = 0;
  int   div    = 0;

  button_debouncer #(
    .WIDTH        (W),
    .PULSE_CNT_MAX(PM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_pulse (sample_pulse),
    .glitchy_in   (glitchy_in),
    .debounced_out(debounced_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample strobe: one cycle in ten, or every cycle while cont is set.
  initial begin
    sample_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (cont) begin
        sample_pulse = 1'b1;
      end else begin
        sample_pulse = (div == 9);
        div = (div == 9) ? 0 : div + 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (sample_pulse) n_samp++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((rise_pulse | fall_pulse) !== '0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_pulse: got rise=%b fall=%b expected none",
                   rise_pulse, fall_pulse);
        end else begin
          e = exp_q.pop_front();
          chk("edge_value", {26'd0, rise_pulse, fall_pulse, debounced_out},
              {26'd0, e.rise, e.fall, e.deb});
          chk("edge_sample_index", n_samp, e.samp);
        end
      end
    end
  end

  task automatic wait_samp(input int k);
    for (int i = 0; i < k; i++) begin
      do @(posedge clk); while (sample_pulse !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic expect_edge(input logic [1:0] r, input logic [1:0] f,
                             input logic [1:0] d, input int offs);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.deb  = d;
    e.samp = n_samp + offs;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n      = 1'b0;
    glitchy_in = '0;
    #3;
    chk("reset_debounced", debounced_out, 0);
    chk("reset_rise", rise_pulse, 0);
    chk("reset_fall", fall_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_samp(1);

    // Clean press on channel 0.
    glitchy_in = 2'b01;
    expect_edge(2'b01, 2'b00, 2'b01, PM);
    wait_samp(PM + 1);
    chk("press_level", debounced_out, 2'b01);

    // Release with one bounce back to 1 after the second sample.
    glitchy_in = 2'b00;
    wait_samp(2);
    glitchy_in = 2'b01;
    wait_samp(1);
    glitchy_in = 2'b00;
    expect_edge(2'b00, 2'b01, 2'b00, PM);
    wait_samp(PM + 1);
    chk("release_level", debounced_out, 2'b00);

    // Glitch of PM-1 samples must not toggle; the following press must
    // still take a full PM samples, showing the count was cleared.
    glitchy_in = 2'b01;
    wait_samp(PM - 1);
    glitchy_in = 2'b00;
    wait_samp(3);
    chk("glitch_level", debounced_out, 2'b00);
    glitchy_in = 2'b01;
    expect_edge(2'b01, 2'b00, 2'b01, PM);
    wait_samp(PM + 1);
    glitchy_in = 2'b00;
    expect_edge(2'b00, 2'b01, 2'b00, PM);
    wait_samp(PM + 1);

    // Independent channels, rising one sample apart.
    glitchy_in = 2'b01;
    expect_edge(2'b01, 2'b00, 2'b01, PM);
    wait_samp(1);
    glitchy_in = 2'b11;
    expect_edge(2'b10, 2'b00, 2'b11, PM);
    wait_samp(PM + 1);
    chk("indep_level", debounced_out, 2'b11);

    // Both channels fall on the same sample.
    glitchy_in = 2'b00;
    expect_edge(2'b00, 2'b11, 2'b00, PM);
    wait_samp(PM + 1);

    // Async reset between clock edges after PM-1 disagreeing samples.
    glitchy_in = 2'b01;
    wait_samp(PM - 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_debounced", debounced_out, 0);
    chk("async_rst_rise", rise_pulse, 0);
    chk("async_rst_fall", fall_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_edge(2'b01, 2'b00, 2'b01, PM);
    wait_samp(PM + 1);
    chk("post_reset_level", debounced_out, 2'b01);

    // Continuous strobe: 2 sync cycles then PM samples, one per cycle.
    cont = 1'b1;
    repeat (3) @(negedge clk);
    glitchy_in = 2'b11;
    expect_edge(2'b10, 2'b00, 2'b11, 2 + PM);
    repeat (10) @(negedge clk);
    chk("cont_level", debounced_out, 2'b11);
    cont = 1'b0;
    repeat (20) @(negedge clk);

    chk("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
